// File: rtl/mult8_sequencer.sv
// 8x8 unsigned multiplier sequenced over one shared 4x4 multiplier.
// Optional MULT8_SEQ_ZERO_BYPASS_EN: zero operands skip straight to DONE.
module mult4x4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] Product
);
  assign Product = {4'b0, A} * {4'b0, B};
endmodule

module mult8_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Product,
  output logic        busy
);
  typedef enum logic [2:0] {
    IDLE, PP0, PP1, PP2, PP3, DONE
  } state_t;

  state_t      state;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] acc;
  logic [3:0]  ma;
  logic [3:0]  mb;
  logic [7:0]  mp;
  logic [15:0] pp_s0;
  logic [15:0] pp_s4;
  logic [15:0] pp_s8;

  // Nibble selection for the shared multiplier; idle states feed zeros
  always_comb begin
    ma = 4'h0;
    mb = 4'h0;
    unique case (state)
      PP0: begin ma = a_q[3:0]; mb = b_q[3:0]; end
      PP1: begin ma = a_q[3:0]; mb = b_q[7:4]; end
      PP2: begin ma = a_q[7:4]; mb = b_q[3:0]; end
      PP3: begin ma = a_q[7:4]; mb = b_q[7:4]; end
      default: begin ma = 4'h0; mb = 4'h0; end
    endcase
  end

  mult4x4 u_mul (
    .A       (ma),
    .B       (mb),
    .Product (mp)
  );

  assign pp_s0 = {8'h00, mp};
  assign pp_s4 = {4'h0, mp, 4'h0};
  assign pp_s8 = {mp, 8'h00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      acc     <= 16'h0000;
      Product <= 16'h0000;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= A;
            b_q <= B;
            acc <= 16'h0000;
`ifdef MULT8_SEQ_ZERO_BYPASS_EN
            if (A == 8'h00 || B == 8'h00) begin
              Product <= 16'h0000;
              state   <= DONE;
            end else begin
              state <= PP0;
            end
`else
            state <= PP0;
`endif
          end
        end
        PP0: begin
          acc   <= acc + pp_s0;
          state <= PP1;
        end
        PP1: begin
          acc   <= acc + pp_s4;
          state <= PP2;
        end
        PP2: begin
          acc   <= acc + pp_s4;
          state <= PP3;
        end
        // Only the final sum ever reaches Product
        PP3: begin
          Product <= acc + pp_s8;
          state   <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_mult8_sequencer.sv
// Scoreboard bench for mult8_sequencer: directed vectors,
// expected results queued by the driver and checked by a monitor.
module tb_mult8_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Product;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] prod;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];

`ifdef MULT8_SEQ_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 5;
`endif

  mult8_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Product   (Product),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: latency on first out_valid, stability while stalled,
  // product on handshake.
  bit          seen = 0;
  logic [15:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        held = Product;
        if (sb.size() == 0) check("unexpected_out", 1, 0);
        else check("latency", cyc - sb[0].acc_cyc + 1, sb[0].lat);
      end else begin
        check("hold_stable", Product, held);
      end
      if (out_ready) begin
        seen = 0;
        if (sb.size() != 0) begin
          check("product", Product, sb[0].prod);
          void'(sb.pop_front());
        end
      end
    end
  end

  int last_acc = -100;

  // Caller is aligned just after a rising edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] p, input int lat,
                       input bit hold);
    exp_t e;
    int n = 0;
    A = a;
    B = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    e.prod = p;
    e.lat = lat;
    e.acc_cyc = cyc + 1;
    last_acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && in_ready) break;
      n++;
      if (n > 60) begin
        check("idle_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a1;
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = 8'h00;
    B = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", Product, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(8'h12, 8'h34, 16'h03A8, 5, 0);
    wait_idle();
    check("one_cycle_wide", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    check("retain", Product, 16'h03A8);

    issue(8'hFF, 8'hFF, 16'hFE01, 5, 1);
    a1 = last_acc;
    issue(8'hA5, 8'h3C, 16'h26AC, 5, 0);
    check("b2b_gap_ge6", (last_acc - a1) >= 6, 1);
    wait_idle();

    out_ready = 1'b0;
    issue(8'h0F, 8'hF0, 16'h0E10, 5, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      check("stall_prod", Product, 16'h0E10);
      check("stall_in_ready", in_ready, 0);
      check("stall_busy", busy, 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("hs_in_ready_low", in_ready, 0);
    @(negedge clk);
    check("idle_after_hs", in_ready, 1);
    @(posedge clk);
    #1;

    issue(8'h03, 8'h05, 16'h000F, 5, 0);
    A = 8'h77;
    B = 8'h77;
    wait_idle();

    issue(8'h40, 8'h40, 16'h1000, 5, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    check("abort_product", Product, 16'h0000);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_result", out_valid, 0);
    end
    @(posedge clk);
    #1;
    issue(8'h02, 8'h03, 16'h0006, 5, 0);
    wait_idle();

    issue(8'h00, 8'h9C, 16'h0000, ZLAT, 0);
    wait_idle();

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mult8_sequencer.md
MULT8_SEQUENCER -- requirements
Module: mult8_sequencer

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 8 bits and result width at 16 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  requester presents A/B.
REQ-005 in_ready  output  1  sequencer can accept an operand pair.
REQ-006 A  input  8  multiplicand, unsigned.
REQ-007 B  input  8  multiplier, unsigned.
REQ-008 out_valid  output  1  Product holds a completed result.
REQ-009 out_ready  input  1  consumer accepts Product.
REQ-010 Product  output  16  registered unsigned A*B.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The block SHALL compute each 8x8 product by time-sharing one internal instance of the team's 4x4 Multiplier (A[3:0], B[3:0] -> Product[7:0]) over four partial-product cycles.
REQ-013 FSM states SHALL be IDLE, PP0, PP1, PP2, PP3, DONE.
REQ-014 in_ready SHALL equal (state==IDLE); an accept SHALL occur on any edge where in_valid && in_ready.
REQ-015 On accept, A and B SHALL be captured into internal registers, the 16-bit accumulator cleared, and state SHALL move IDLE->PP0; later changes on A/B SHALL be ignored until the next accept.
REQ-016 Partial-product order SHALL be: PP0 = AL*BL (shift 0), PP1 = AL*BH (shift 4), PP2 = AH*BL (shift 4), PP3 = AH*BH (shift 8); each is added into the accumulator in its own cycle.
REQ-017 Transitions PP0->PP1->PP2->PP3->DONE SHALL be unconditional, one per cycle.
REQ-018 At the PP3 edge, Product SHALL be loaded with the final sum (accumulator + AH*BH<<8); Product SHALL never expose intermediate sums.
REQ-019 Latency: accept at edge N -> out_valid high after edge N+5.
REQ-020 out_valid SHALL equal (state==DONE); Product SHALL be held stable while out_valid && !out_ready.
REQ-021 DONE->IDLE SHALL occur only on out_valid && out_ready; in_ready SHALL NOT rise in that same cycle, so the earliest next accept is the following edge (minimum 6 cycles per operation).
REQ-022 After handshake, Product SHALL retain the last result until the next PP3 load.
REQ-023 Multiplier instance inputs SHALL be driven to 0 in IDLE and DONE.
REQ-024 Sums SHALL be computed at 16 bits with no truncation; 0xFF*0xFF SHALL yield 0xFE01.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, operand registers=0, accumulator=0, Product=0x0000, out_valid=0, busy=0; in_ready SHALL be 1 after reset.
REQ-026 Reset asserted during any PP state or DONE SHALL abort the operation with no result delivered; the first accept after rst_n deasserts SHALL start a fresh computation.

Configuration
REQ-027 Macro MULT8_SEQ_ZERO_BYPASS_EN: when defined, an accept with A==0 or B==0 SHALL go IDLE->DONE directly, loading Product=0x0000, with out_valid high after edge N+1.
REQ-028 Without MULT8_SEQ_ZERO_BYPASS_EN, zero operands SHALL traverse PP0..PP3 with the normal 5-cycle latency.

Verification
REQ-029 A=0x12, B=0x34, out_ready=1 -> Product=0x03A8, out_valid high exactly 5 cycles after accept, one cycle wide.
REQ-030 A=0xFF, B=0xFF, then A=0xA5, B=0x3C back-to-back with in_valid held -> 0xFE01, then 0x26AC; second accept not earlier than 6 cycles after the first.
REQ-031 A=0x0F, B=0xF0, out_ready low 3 cycles after out_valid -> Product held at 0x0E10, in_ready=0 and busy=1 throughout; IDLE one cycle after out_ready rises.
REQ-032 Change A/B to 0x77/0x77 during PP1 of an accepted 0x03*0x05 -> Product=0x000F.
REQ-033 rst_n pulsed low during PP2 -> Product=0, out_valid=0, in_ready=1 immediately; no result delivered; next 0x02*0x03 -> 0x0006.
REQ-034 A=0x00, B=0x9C -> Product=0x0000 at latency 1 with MULT8_SEQ_ZERO_BYPASS_EN, latency 5 without.
